// File: rtl/frame_reader_if.sv
// RAM read port and outgoing sample stream of frame_reader.
// master = the reader, slave = RAM + downstream consumer.
interface frame_reader_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 9
) ();
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] frame_data;
  logic              frame_valid;
  logic              frame_ready;
  logic              frame_first;
  logic              frame_last;

  modport master (
    output rd_addr, rd_en, frame_data, frame_valid, frame_first, frame_last,
    input  rd_data, frame_ready
  );

  modport slave (
    input  rd_addr, rd_en, frame_data, frame_valid, frame_first, frame_last,
    output rd_data, frame_ready
  );
endinterface

// File: rtl/frame_reader.sv
// Ping-pong bank reader: queues filled banks and streams each one as a
// zero-padded FRAME_LEN-sample frame over a valid/ready handshake.
module frame_reader #(
  parameter int FRAME_LEN  = 256,
  parameter int BANK_DEPTH = 200,
  parameter int DATA_W     = 12
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           bank0_full,
  input  logic           bank1_full,
  input  logic           memorization_completed,
  input  logic [7:0]     idx_final,
  input  logic           wr_bank,
  frame_reader_if.master bus,
  output logic           overrun
);
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int LEN_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_PAD, S_DRAIN} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } ent_t;

  state_t                state_q, state_d;
  logic                  bank_q, bank_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            pend_vld_q, pend_vld_d;
  logic [1:0][LEN_W-1:0] pend_len_q, pend_len_d;
  logic                  old_q, old_d;
  logic                  full_seen_q, full_seen_d;
  logic                  overrun_q, overrun_d;
  logic                  issue_q, issue_d, zero_q, zero_d;
  logic                  ifirst_q, ifirst_d, ilast_q, ilast_d;
  logic                  rd_en_q, rd_en_d;
  logic [CNT_W:0]        rd_addr_q, rd_addr_d;
  logic                  stage_vld_q, stage_vld_d, stage_zero_q, stage_zero_d;
  logic                  stage_first_q, stage_first_d, stage_last_q, stage_last_d;
  ent_t                  fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]            count_q, count_d;

  ent_t                  stage_ent, head;
  logic                  frame_valid, pop, issue_ok, mc_ok, sel;
  logic [1:0]            set_b, vld_cl;
  logic [1:0][LEN_W-1:0] set_len;

  always_comb begin
    state_d = state_q; bank_d = bank_q; len_d = len_q; cnt_d = cnt_q;
    pend_vld_d = pend_vld_q; pend_len_d = pend_len_q; old_d = old_q;
    overrun_d = overrun_q; full_seen_d = bank0_full | bank1_full;
    issue_d = 1'b0; zero_d = 1'b0; ifirst_d = 1'b0; ilast_d = 1'b0;
    rd_en_d = 1'b0; rd_addr_d = rd_addr_q;
    stage_vld_d = issue_q; stage_zero_d = zero_q;
    stage_first_d = ifirst_q; stage_last_d = ilast_q;
    fifo0_d = fifo0_q; fifo1_d = fifo1_q; count_d = count_q;
    sel = 1'b0;

    // The stage slot holds the item whose RAM data is on rd_data this cycle;
    // it is offered downstream directly when the FIFO is empty.
    stage_ent.data  = stage_zero_q ? '0 : bus.rd_data;
    stage_ent.first = stage_first_q;
    stage_ent.last  = stage_last_q;
    frame_valid = (count_q != 2'd0) || stage_vld_q;
    head = (count_q != 2'd0) ? fifo0_q : (stage_vld_q ? stage_ent : '0);
    pop  = frame_valid && bus.frame_ready;

    if (pop && count_q != 2'd0) begin
      fifo0_d = fifo1_q;
      count_d = count_q - 2'd1;
    end
    if (stage_vld_q && !(pop && count_q == 2'd0)) begin
      if (count_d == 2'd0) fifo0_d = stage_ent;
      else fifo1_d = stage_ent;
      count_d = count_d + 2'd1;
    end
    issue_ok = ({1'b0, count_d} + {2'b00, issue_q}) < 3'd2;

    case (state_q)
      S_IDLE: if (pend_vld_q != 2'b00) begin
        sel = (&pend_vld_q) ? old_q : pend_vld_q[1];
        pend_vld_d[sel] = 1'b0;
        bank_d  = sel;
        len_d   = pend_len_q[sel];
        cnt_d   = '0;
        state_d = S_READ;
      end
      S_READ: if (issue_ok) begin
        issue_d   = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = {bank_q, cnt_q};
        ifirst_d  = (cnt_q == '0);
        ilast_d   = (cnt_q == CNT_W'(FRAME_LEN - 1));
        cnt_d     = cnt_q + 1'b1;
        if (LEN_W'(cnt_q) == len_q - LEN_W'(1))
          state_d = (len_q == LEN_W'(FRAME_LEN)) ? S_DRAIN : S_PAD;
      end
      S_PAD: if (issue_ok) begin
        issue_d = 1'b1;
        zero_d  = 1'b1;
        ilast_d = (cnt_q == CNT_W'(FRAME_LEN - 1));
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (count_q == 2'd0 && !stage_vld_q && !issue_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A completion right after a full pulse carries a stale index and is dropped.
    vld_cl  = pend_vld_d;
    set_b   = {bank1_full, bank0_full};
    set_len = {2{LEN_W'(BANK_DEPTH)}};
    mc_ok   = memorization_completed && !full_seen_q;
    if (mc_ok) begin
      set_b[wr_bank]   = 1'b1;
      set_len[wr_bank] = LEN_W'(idx_final) + LEN_W'(1);
    end
    for (int b = 0; b < 2; b++) begin
      if (set_b[b]) begin
        if (pend_vld_q[b] || (state_q == S_READ && bank_q == 1'(b))) overrun_d = 1'b1;
        pend_vld_d[b] = 1'b1;
        pend_len_d[b] = set_len[b];
      end
    end
    if (&set_b) old_d = 1'b0;
    else if (set_b[0]) old_d = vld_cl[1];
    else if (set_b[1]) old_d = !vld_cl[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; bank_q <= 1'b0; len_q <= '0; cnt_q <= '0;
      pend_vld_q <= '0; pend_len_q <= '0; old_q <= 1'b0;
      full_seen_q <= 1'b0; overrun_q <= 1'b0;
      issue_q <= 1'b0; zero_q <= 1'b0; ifirst_q <= 1'b0; ilast_q <= 1'b0;
      rd_en_q <= 1'b0; rd_addr_q <= '0;
      stage_vld_q <= 1'b0; stage_zero_q <= 1'b0;
      stage_first_q <= 1'b0; stage_last_q <= 1'b0;
      fifo0_q <= '0; fifo1_q <= '0; count_q <= '0;
    end else begin
      state_q <= state_d; bank_q <= bank_d; len_q <= len_d; cnt_q <= cnt_d;
      pend_vld_q <= pend_vld_d; pend_len_q <= pend_len_d; old_q <= old_d;
      full_seen_q <= full_seen_d; overrun_q <= overrun_d;
      issue_q <= issue_d; zero_q <= zero_d; ifirst_q <= ifirst_d; ilast_q <= ilast_d;
      rd_en_q <= rd_en_d; rd_addr_q <= rd_addr_d;
      stage_vld_q <= stage_vld_d; stage_zero_q <= stage_zero_d;
      stage_first_q <= stage_first_d; stage_last_q <= stage_last_d;
      fifo0_q <= fifo0_d; fifo1_q <= fifo1_d; count_q <= count_d;
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.frame_valid = frame_valid;
  assign bus.frame_data  = head.data;
  assign bus.frame_first = head.first;
  assign bus.frame_last  = head.last;
  assign overrun         = overrun_q;
endmodule
